// File: rtl/abc_sequencer_pkg.sv
// Shared constants and mode encoding for the a/b/c operand sequencer.
package abc_sequencer_pkg;

  // Width of the operand code driven onto a/b/c
  localparam int CODE_W = 3;

  // Sequencer operating mode
  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

endpackage

// File: rtl/abc_sequencer_button_conditioner.sv
// Raw pushbutton -> synchronised, debounced level plus a 1-cycle rising pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_deb;
  logic        r_deb_prev;
  logic [15:0] r_cnt;

  // Two-flop synchroniser, mismatch-run counter and debounced level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_deb      <= 1'b0;
      r_deb_prev <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= btn_raw;
      r_sync2    <= r_sync1;
      r_deb_prev <= r_deb;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // Mismatch has held for the full window: accept the new level
        r_deb <= ~r_deb;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign level = r_deb;
  // Both terms are registered, so the pulse is glitch-free and one cycle wide
  assign rise  = r_deb & ~r_deb_prev;

endmodule

// File: rtl/abc_sequencer.sv
// Operand generator: manual stepping or periodic auto sweep of the 3-bit a/b/c code.
module abc_sequencer
  import abc_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_CYCLES     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_step,
  input  logic btn_mode,
  output logic a,
  output logic b,
  output logic c,
  output logic auto_mode,
  output logic step_pulse
);

  localparam logic [23:0] TIMER_LAST = 24'(STEP_CYCLES - 1);

  logic              w_step_rise;
  logic              w_mode_rise;
  logic              w_unused_step_level;
  logic              w_unused_mode_level;

  mode_e             r_mode;
  logic [CODE_W-1:0] r_code;
  logic [23:0]       r_timer;
  logic              r_step_pulse;

  mode_e             w_mode_nxt;
  logic [CODE_W-1:0] w_code_nxt;
  logic [23:0]       w_timer_nxt;
  logic              w_pulse_nxt;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_step),
    .level   (w_unused_step_level),
    .rise    (w_step_rise)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_mode),
    .level   (w_unused_mode_level),
    .rise    (w_mode_rise)
  );

  // State, timer, code and strobe registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode       <= MODE_MANUAL;
      r_code       <= '0;
      r_timer      <= '0;
      r_step_pulse <= 1'b0;
    end else begin
      r_mode       <= w_mode_nxt;
      r_code       <= w_code_nxt;
      r_timer      <= w_timer_nxt;
      r_step_pulse <= w_pulse_nxt;
    end
  end

  // Next-state logic; a mode rise always wins over a step rise or timer terminal count
  always_comb begin
    w_mode_nxt  = r_mode;
    w_code_nxt  = r_code;
    w_timer_nxt = r_timer;
    w_pulse_nxt = 1'b0;
    case (r_mode)
      MODE_MANUAL: begin
        if (w_mode_rise) begin
          w_mode_nxt  = MODE_AUTO;
          w_timer_nxt = '0;
        end else if (w_step_rise) begin
          w_code_nxt  = r_code + CODE_W'(1);
          w_pulse_nxt = 1'b1;
        end
      end
      MODE_AUTO: begin
        if (w_mode_rise) begin
          w_mode_nxt  = MODE_MANUAL;
          w_timer_nxt = '0;
        end else if (r_timer == TIMER_LAST) begin
          w_timer_nxt = '0;
          w_code_nxt  = r_code + CODE_W'(1);
          w_pulse_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 24'd1;
        end
      end
      default: begin
        w_mode_nxt  = MODE_MANUAL;
        w_timer_nxt = '0;
      end
    endcase
  end

  assign a          = r_code[2];
  assign b          = r_code[1];
  assign c          = r_code[0];
  assign auto_mode  = (r_mode == MODE_AUTO);
  assign step_pulse = r_step_pulse;

endmodule
